trap_ctrl: RTL and testbench

Sequences the machine-mode trap and return flow around the CSR file. It accepts synchronous exceptions, mret requests and the three machine interrupt sources. It arbitrates between them with fixed priority and drives a single-cycle trap/mret pulse into the CSR file. It then stalls and flushes the pipeline and issues one fetch redirect to the vectored trap target or to mepc.

---
 rtl/trap_ctrl.sv | 155 +++++++++++++++
 tb/tb_trap_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: arbitrates exceptions, mret and interrupts, pulses the
// CSR file, then stalls/flushes the pipeline and issues one fetch redirect.
module trap_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IRQ_SYNC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_valid_i,
  input  logic [3:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_req_i,
  input  logic            instr_valid_i,
  input  logic [XLEN-1:0] instr_pc_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  input  logic            irq_soft_i,
  input  logic            mstatus_mie_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_target_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic [XLEN-1:0] mip_o,
  output logic            trap_req_o,
  output logic            trap_intr_o,
  output logic [3:0]      trap_cause_o,
  output logic [XLEN-1:0] trap_epc_o,
  output logic [XLEN-1:0] trap_tval_o,
  output logic            mret_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {StIdle, StTrap, StWait, StRet, StRedir} state_e;

  state_e            state_q, state_d;
  logic [IRQ_SYNC-1:0] sync_q;
  logic [3:0]        cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic              intr_q, intr_d;
  logic              sel_vec_q, sel_vec_d;
  logic [XLEN-1:0]   pend;
  logic              irq_ok;
  logic [3:0]        irq_cause;
  logic              unused_pend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      state_q   <= StIdle;
      cause_q   <= '0;
      epc_q     <= '0;
      tval_q    <= '0;
      intr_q    <= 1'b0;
      sel_vec_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[IRQ_SYNC-2:0], irq_ext_i};
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      tval_q    <= tval_d;
      intr_q    <= intr_d;
      sel_vec_q <= sel_vec_d;
    end
  end

  always_comb begin
    mip_o     = '0;
    mip_o[11] = sync_q[IRQ_SYNC-1];
    mip_o[7]  = irq_timer_i;
    mip_o[3]  = irq_soft_i;
  end

  assign pend        = mip_o & mie_i;
  assign unused_pend = ^pend;
  assign irq_ok      = instr_valid_i & mstatus_mie_i & (pend[11] | pend[3] | pend[7]);
  assign irq_cause   = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    tval_d           = tval_q;
    intr_d           = intr_q;
    sel_vec_d        = sel_vec_q;
    trap_req_o       = 1'b0;
    trap_intr_o      = 1'b0;
    trap_cause_o     = '0;
    trap_epc_o       = '0;
    trap_tval_o      = '0;
    mret_o           = 1'b0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;

    unique case (state_q)
      StIdle: begin
        if (exc_valid_i) begin
          state_d   = StTrap;
          cause_d   = exc_cause_i;
          epc_d     = exc_pc_i;
          tval_d    = exc_tval_i;
          intr_d    = 1'b0;
          sel_vec_d = 1'b1;
        end else if (mret_req_i) begin
          state_d   = StRet;
          sel_vec_d = 1'b0;
        end else if (irq_ok) begin
          state_d   = StTrap;
          cause_d   = irq_cause;
          epc_d     = instr_pc_i;
          tval_d    = '0;
          intr_d    = 1'b1;
          sel_vec_d = 1'b1;
        end
      end
      StTrap: begin
        trap_req_o   = 1'b1;
        trap_intr_o  = intr_q;
        trap_cause_o = cause_q;
        trap_epc_o   = epc_q;
        trap_tval_o  = tval_q;
        flush_o      = 1'b1;
        stall_o      = 1'b1;
        state_d      = StWait;
      end
      // Gives the CSR file a cycle so mtvec_target reflects the new mcause.
      StWait: begin
        stall_o = 1'b1;
        state_d = StRedir;
      end
      StRet: begin
        mret_o  = 1'b1;
        flush_o = 1'b1;
        stall_o = 1'b1;
        state_d = StRedir;
      end
      StRedir: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = sel_vec_q ? mtvec_target_i : mepc_i;
        stall_o          = 1'b1;
        state_d          = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: expected pulses are queued at stimulus time and
// popped as the DUT emits trap/mret/redirect pulses.
module tb_trap_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            exc_valid, mret_req, instr_valid;
  logic [3:0]      exc_cause;
  logic [XLEN-1:0] exc_pc, exc_tval, instr_pc;
  logic            irq_ext, irq_timer, irq_soft, mstatus_mie;
  logic [XLEN-1:0] mie, mtvec_target, mepc;
  logic [XLEN-1:0] mip;
  logic            trap_req, trap_intr, mret_out, flush, stall, redirect_valid, busy;
  logic [3:0]      trap_cause;
  logic [XLEN-1:0] trap_epc, trap_tval, redirect_pc;

  trap_ctrl #(.XLEN(XLEN), .IRQ_SYNC(SYNC)) dut (
    .clk              (clk),
    .rst              (rst),
    .exc_valid_i      (exc_valid),
    .exc_cause_i      (exc_cause),
    .exc_pc_i         (exc_pc),
    .exc_tval_i       (exc_tval),
    .mret_req_i       (mret_req),
    .instr_valid_i    (instr_valid),
    .instr_pc_i       (instr_pc),
    .irq_ext_i        (irq_ext),
    .irq_timer_i      (irq_timer),
    .irq_soft_i       (irq_soft),
    .mstatus_mie_i    (mstatus_mie),
    .mie_i            (mie),
    .mtvec_target_i   (mtvec_target),
    .mepc_i           (mepc),
    .mip_o            (mip),
    .trap_req_o       (trap_req),
    .trap_intr_o      (trap_intr),
    .trap_cause_o     (trap_cause),
    .trap_epc_o       (trap_epc),
    .trap_tval_o      (trap_tval),
    .mret_o           (mret_out),
    .flush_o          (flush),
    .stall_o          (stall),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  // kind: 0 trap, 1 mret, 2 redirect; lat = negedges since the previous observation
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  lat;
    logic [68:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  n_overlap = 0;
  int  n_long = 0;
  logic prev_trap = 1'b0, prev_mret = 1'b0, prev_redir = 1'b0;

  always @(negedge clk) begin
    if (int'(trap_req) + int'(mret_out) + int'(redirect_valid) > 1) n_overlap++;
    if ((trap_req && prev_trap) || (mret_out && prev_mret) || (redirect_valid && prev_redir))
      n_long++;
    prev_trap  = trap_req;
    prev_mret  = mret_out;
    prev_redir = redirect_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  function automatic logic [68:0] observe(input int k);
    case (k)
      0:       return {trap_intr, trap_cause, trap_epc, trap_tval};
      1:       return {67'b0, flush, stall};
      2:       return {37'b0, redirect_pc};
      default: return '0;
    endcase
  endfunction

  task automatic wait_event(input int budget, output int kind, output int cycles);
    kind = -1;
    for (cycles = 1; cycles <= budget; cycles++) begin
      @(negedge clk);
      if (trap_req) begin kind = 0; return; end
      if (mret_out) begin kind = 1; return; end
      if (redirect_valid) begin kind = 2; return; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; exc_valid = 0; mret_req = 0; instr_valid = 0; exc_cause = '0;
    exc_pc = '0; exc_tval = '0; instr_pc = '0; irq_ext = 0; irq_timer = 0; irq_soft = 0;
    mstatus_mie = 0; mie = '0; mtvec_target = '0; mepc = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({trap_req, trap_intr, trap_cause, trap_epc, trap_tval, mret_out, flush, stall,
         redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL reset_outputs got req=%b mret=%b flush=%b stall=%b redir=%b busy=%b exp all 0",
               trap_req, mret_out, flush, stall, redirect_valid, busy);
    else n_pass++;
    n_total++;
    if (mip !== '0) $display("FAIL reset_mip got %h exp 0", mip);
    else n_pass++;
  endtask

  task automatic test_exception;
    int k, c;
    ev_t e;
    @(posedge clk); #1;
    exc_valid = 1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    mtvec_target = 32'h80;
    exp_q.push_back('{2'd0, 4'd1, {1'b0, 4'd2, 32'h100, 32'hDEAD}});
    exp_q.push_back('{2'd2, 4'd1, {37'b0, 32'h80}});
    @(posedge clk); #1 exc_valid = 0;
    wait_event(8, k, c); e = exp_q.pop_front(); n_total++;
    if ({k[1:0], c[3:0], observe(k)} !== {e.kind, e.lat, e.data})
      $display("FAIL exc_trap got kind=%0d lat=%0d data=%h exp kind=%0d lat=%0d data=%h",
               k, c, observe(k), e.kind, e.lat, e.data);
    else n_pass++;
    @(negedge clk); n_total++;
    if ({trap_req, trap_cause, trap_epc, trap_tval, stall, flush} !== {1'b0, 68'b0, 1'b1, 1'b0})
      $display("FAIL exc_wait_state got req=%b cause=%h epc=%h tval=%h stall=%b flush=%b exp 0/0/0/0/1/0",
               trap_req, trap_cause, trap_epc, trap_tval, stall, flush);
    else n_pass++;
    wait_event(8, k, c); e = exp_q.pop_front(); n_total++;
    if ({k[1:0], c[3:0], observe(k)} !== {e.kind, e.lat, e.data})
      $display("FAIL exc_redirect got kind=%0d lat=%0d data=%h exp kind=%0d lat=%0d data=%h",
               k, c, observe(k), e.kind, e.lat, e.data);
    else n_pass++;
    @(negedge clk); n_total++;
    if ({busy, stall} !== 2'b00) $display("FAIL exc_idle got busy=%b stall=%b exp 0 0", busy, stall);
    else n_pass++;
  endtask

  task automatic test_irq_priority;
    int k, c;
    ev_t e;
    @(posedge clk); #1;
    mstatus_mie = 1; mie = 32'h888; irq_timer = 1; irq_soft = 1; instr_valid = 1;
    instr_pc = 32'h200; mtvec_target = 32'h80;
    exp_q.push_back('{2'd0, 4'd1, {1'b1, 4'd3, 32'h200, 32'h0}});
    exp_q.push_back('{2'd2, 4'd2, {37'b0, 32'h80}});
    exp_q.push_back('{2'd0, 4'd2, {1'b1, 4'd7, 32'h200, 32'h0}});
    exp_q.push_back('{2'd2, 4'd2, {37'b0, 32'h80}});
    @(posedge clk); #1 irq_soft = 0;
    for (int i = 0; i < 4; i++) begin
      wait_event(8, k, c); e = exp_q.pop_front(); n_total++;
      if ({k[1:0], c[3:0], observe(k)} !== {e.kind, e.lat, e.data})
        $display("FAIL irq_event%0d got kind=%0d lat=%0d data=%h exp kind=%0d lat=%0d data=%h",
                 i, k, c, observe(k), e.kind, e.lat, e.data);
      else n_pass++;
      if (i == 2) irq_timer = 0;
    end
    @(negedge clk); n_total++;
    if (busy !== 1'b0) $display("FAIL irq_idle got busy=%b exp 0", busy);
    else n_pass++;
    instr_valid = 0; mstatus_mie = 0;
  endtask

  task automatic test_ext_sync;
    logic [4:0] exp_bit;
    exp_bit = 5'b01110;
    @(posedge clk); #1;
    mstatus_mie = 0; mie = 32'h888; instr_valid = 1; irq_ext = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      if (i == 2) #1 irq_ext = 0;
      @(negedge clk); n_total++;
      if ({mip, busy} !== {(exp_bit[i] ? 32'h800 : 32'h0), 1'b0})
        $display("FAIL ext_sync%0d got mip=%h busy=%b exp mip=%h busy=0",
                 i, mip, busy, (exp_bit[i] ? 32'h800 : 32'h0));
      else n_pass++;
    end
    instr_valid = 0;
  endtask

  task automatic test_exc_vs_mret;
    int k, c;
    ev_t e;
    @(posedge clk); #1;
    exc_valid = 1; mret_req = 1; exc_cause = 4'd5; exc_pc = 32'h300; exc_tval = 32'h44;
    mtvec_target = 32'h80; mepc = 32'h104;
    exp_q.push_back('{2'd0, 4'd1, {1'b0, 4'd5, 32'h300, 32'h44}});
    exp_q.push_back('{2'd2, 4'd2, {37'b0, 32'h80}});
    @(posedge clk); #1 begin exc_valid = 0; mret_req = 0; end
    for (int i = 0; i < 2; i++) begin
      wait_event(8, k, c); e = exp_q.pop_front(); n_total++;
      if ({k[1:0], c[3:0], observe(k)} !== {e.kind, e.lat, e.data})
        $display("FAIL exc_mret_event%0d got kind=%0d lat=%0d data=%h exp kind=%0d lat=%0d data=%h",
                 i, k, c, observe(k), e.kind, e.lat, e.data);
      else n_pass++;
    end
    @(posedge clk); #1 mret_req = 1;
    exp_q.push_back('{2'd1, 4'd1, {67'b0, 2'b11}});
    exp_q.push_back('{2'd2, 4'd1, {37'b0, 32'h104}});
    @(posedge clk); #1 mret_req = 0;
    for (int i = 0; i < 2; i++) begin
      wait_event(8, k, c); e = exp_q.pop_front(); n_total++;
      if ({k[1:0], c[3:0], observe(k)} !== {e.kind, e.lat, e.data})
        $display("FAIL mret_event%0d got kind=%0d lat=%0d data=%h exp kind=%0d lat=%0d data=%h",
                 i, k, c, observe(k), e.kind, e.lat, e.data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int redirs;
    redirs = 0;
    @(posedge clk); #1;
    exc_valid = 1; exc_cause = 4'd1; exc_pc = 32'h400; exc_tval = 32'h0;
    @(posedge clk); #1 exc_valid = 0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); n_total++;
    if ({trap_req, mret_out, flush, stall, redirect_valid, redirect_pc, busy} !== '0)
      $display("FAIL reset_mid_outputs got req=%b mret=%b flush=%b stall=%b redir=%b busy=%b exp all 0",
               trap_req, mret_out, flush, stall, redirect_valid, busy);
    else n_pass++;
    if (redirect_valid) redirs++;
    repeat (4) begin
      @(negedge clk);
      if (redirect_valid || trap_req || mret_out) redirs++;
    end
    n_total++;
    if (redirs !== 0) $display("FAIL reset_mid_pulses got %0d exp 0", redirs);
    else n_pass++;
  endtask

  task automatic test_exclusive;
    n_total++;
    if (n_overlap !== 0) $display("FAIL pulse_overlap got %0d exp 0", n_overlap);
    else n_pass++;
    n_total++;
    if (n_long !== 0) $display("FAIL pulse_length got %0d multi-cycle pulses exp 0", n_long);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_exception();
    test_irq_priority();
    test_ext_sync();
    test_exc_vs_mret();
    test_reset_mid();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
